// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device. The host inhibits the clock and
// requests to send, then shifts the 11-bit frame out on device-generated
// clocks and checks the device ACK. Both PS/2 lines are driven only through
// pull-low enables; a released line floats high.
//
// Handshake: a byte is accepted on a clk edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE and tx_valid is ignored in every other state.
// The result is reported by a one-cycle done pulse, with ack_err and
// timeout_err valid from that pulse until the next accept.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // One counter serves the inhibit interval and the transfer timeout,
  // since the two never run at the same time.
  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic [7:0]    tx_byte;
  logic          parity;
  logic [2:0]    clk_s;
  logic [1:0]    data_s;
  logic          fall;
  logic          d_s;

  assign fall      = clk_s[2] & ~clk_s[1];
  assign d_s       = data_s[1];
  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Synchronise the asynchronous PS/2 lines; reset to the idle-high level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s  <= 3'b111;
      data_s <= 2'b11;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk};
      data_s <= {data_s[0], ps2_data};
    end
  end

  // Transfer sequencer: inhibit, request-to-send, frame shift, ACK, bus idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bitcnt       <= 4'd0;
      tx_byte      <= 8'h00;
      parity       <= 1'b0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_low  <= 1'b0;
          ps2_data_low <= 1'b0;
          if (tx_valid) begin
            tx_byte     <= tx_data;
            parity      <= ~^tx_data;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            bitcnt      <= 4'd0;
            cnt         <= '0;
            ps2_clk_low <= 1'b1;
            state       <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt          <= '0;
            ps2_data_low <= 1'b1;
            state        <= S_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REQ: begin
          // Release the clock while the start bit stays driven low.
          ps2_clk_low <= 1'b0;
          cnt         <= '0;
          state       <= S_SEND;
        end
        S_SEND: begin
          // Timeout wins over a falling edge in the same cycle.
          if (cnt == TO_LAST) begin
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            timeout_err  <= 1'b1;
            done         <= 1'b1;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              bitcnt <= bitcnt + 4'd1;
              if (!bitcnt[3]) begin
                ps2_data_low <= ~tx_byte[bitcnt[2:0]];
              end else if (bitcnt == 4'd8) begin
                ps2_data_low <= ~parity;
              end else if (bitcnt == 4'd9) begin
                ps2_data_low <= 1'b0;
              end else begin
                // Device ACK: it should be holding data low on this clock.
                ps2_data_low <= 1'b0;
                ack_err      <= d_s;
                state        <= S_WAIT_IDLE;
              end
            end
          end
        end
        S_WAIT_IDLE: begin
          ps2_clk_low  <= 1'b0;
          ps2_data_low <= 1'b0;
          if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (clk_s[1] && d_s) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          ps2_clk_low  <= 1'b0;
          ps2_data_low <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
